mio_bus_responder: RTL and testbench

- Memory/IO responder on the far side of the CPU's MIO handshake.
- The CPU raises CPU_MIO with an address, write flag and write data. This block decodes the address and performs the access on internal RAM or on peripheral registers (LED, switches, cycle counter).
- It returns read data and pulses MIO_ready after a programmable number of wait states.
- It replaces the tied-high MIO_ready currently used in CPU simulation tops.

---
 rtl/mio_pkg.sv | 26 ++
 rtl/mio_ram.sv | 21 ++
 rtl/mio_bus_responder.sv | 138 +++++++++++++
 tb/tb_mio_bus_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// Shared definitions for the MIO bus responder: address map, FSM states, request payload.
package mio_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LED_W  = 16;

    localparam logic [DATA_W-1:0] LED_ADDR = 32'hF000_0000;
    localparam logic [DATA_W-1:0] SW_ADDR  = 32'hF000_0004;
    localparam logic [DATA_W-1:0] CNT_ADDR = 32'hF000_0008;
    localparam logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP,
        HOLD
    } mio_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } mio_req_t;

endpackage

// File: rtl/mio_ram.sv
// Single-port synchronous RAM, 2^AW x 32, one-cycle registered read.
module mio_ram #(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mio_bus_responder.sv
// MIO responder: decodes CPU requests onto RAM / LED / switch / cycle-counter and pulses MIO_ready.
// Define MIO_ERR_EN to add the bus_err port and the 0xDEAD_BEEF unmapped-read value.
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter int unsigned RAM_AW      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk_100mhz,
    input  logic              rst,
    input  logic              CPU_MIO,
    input  logic              mem_w,
    input  logic [DATA_W-1:0] addr_bus,
    input  logic [DATA_W-1:0] Data_out,
    output logic [DATA_W-1:0] Data_in,
    output logic              MIO_ready,
    input  logic [LED_W-1:0]  sw,
    output logic [LED_W-1:0]  led
`ifdef MIO_ERR_EN
    ,
    output logic              bus_err
`endif
);

    localparam int unsigned WCW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    mio_state_e        state, state_nx;
    mio_req_t          req_q;
    logic [WCW-1:0]    wait_cnt;
    logic [DATA_W-1:0] cnt;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] rd_data_c;
    logic [RAM_AW-1:0] ram_addr_c;
    logic              ram_hit_c, led_hit_c, sw_hit_c, cnt_hit_c;
    logic              access_c, ram_we_c, take_c;

    assign take_c    = (state == IDLE) && CPU_MIO;
    assign access_c  = (state == ACCESS);
    assign ram_hit_c = (req_q.addr[DATA_W-1:RAM_AW+2] == '0);
    assign led_hit_c = (req_q.addr == LED_ADDR);
    assign sw_hit_c  = (req_q.addr == SW_ADDR);
    assign cnt_hit_c = (req_q.addr == CNT_ADDR);
    assign ram_we_c  = access_c && req_q.we && ram_hit_c;
    // RAM reads every cycle so the word for the latched address is on ram_rdata during ACCESS.
    assign ram_addr_c = (state == IDLE) ? addr_bus[RAM_AW+1:2] : req_q.addr[RAM_AW+1:2];

    mio_ram #(.AW(RAM_AW)) u_ram (
        .clk   (clk_100mhz),
        .we    (ram_we_c),
        .addr  (ram_addr_c),
        .wdata (req_q.wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
`ifdef MIO_ERR_EN
        rd_data_c = ERR_DATA;
`else
        rd_data_c = '0;
`endif
        if (ram_hit_c) begin
            rd_data_c = ram_rdata;
        end else if (led_hit_c) begin
            rd_data_c = {{(DATA_W-LED_W){1'b0}}, led};
        end else if (sw_hit_c) begin
            rd_data_c = {{(DATA_W-LED_W){1'b0}}, sw};
        end else if (cnt_hit_c) begin
            rd_data_c = cnt;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (CPU_MIO) state_nx = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
            WAIT:    if (wait_cnt == '0) state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = HOLD;
            HOLD:    if (!CPU_MIO) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            req_q     <= '0;
            wait_cnt  <= '0;
            cnt       <= '0;
            led       <= '0;
            Data_in   <= '0;
            MIO_ready <= 1'b0;
        end else begin
            MIO_ready <= access_c;
            if (take_c) begin
                // Word addressing: byte offset is cleared so exact-match decode ignores it.
                req_q <= '{addr: addr_bus & ~32'h3, we: mem_w, wdata: Data_out};
            end
            if (take_c) begin
                wait_cnt <= WCW'(WAIT_CYCLES - 1);
            end else if (state == WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - WCW'(1);
            end
            if (access_c && req_q.we && cnt_hit_c) begin
                cnt <= req_q.wdata;
            end else begin
                cnt <= cnt + 32'd1;
            end
            if (access_c && req_q.we && led_hit_c) begin
                led <= req_q.wdata[LED_W-1:0];
            end
            if (access_c && !req_q.we) begin
                Data_in <= rd_data_c;
            end
        end
    end

`ifdef MIO_ERR_EN
    logic unmapped_c;
    assign unmapped_c = !(ram_hit_c || led_hit_c || sw_hit_c || cnt_hit_c);

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            bus_err <= 1'b0;
        end else begin
            bus_err <= access_c && (unmapped_c || (sw_hit_c && req_q.we));
        end
    end
`endif

endmodule

// File: tb/tb_mio_bus_responder.sv
// Randomized self-checking bench for mio_bus_responder against a transaction-level model.
module tb_mio_bus_responder;

    localparam int W      = 2;
    localparam int RAM_AW = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        CPU_MIO = 1'b0;
    logic        mem_w = 1'b0;
    logic [31:0] addr_bus = '0;
    logic [31:0] Data_out = '0;
    logic [15:0] sw = '0;
    logic [31:0] Data_in, Data_in0;
    logic        MIO_ready, MIO_ready0;
    logic [15:0] led, led0;
    logic        bus_err = 1'b0;
    logic        bus_err0 = 1'b0;

    mio_bus_responder #(.RAM_AW(RAM_AW), .WAIT_CYCLES(W)) u_dut (
        .clk_100mhz (clk), .rst (rst), .CPU_MIO (CPU_MIO), .mem_w (mem_w),
        .addr_bus (addr_bus), .Data_out (Data_out), .Data_in (Data_in),
        .MIO_ready (MIO_ready), .sw (sw), .led (led)
`ifdef MIO_ERR_EN
        , .bus_err (bus_err)
`endif
    );

    mio_bus_responder #(.RAM_AW(RAM_AW), .WAIT_CYCLES(0)) u_dut0 (
        .clk_100mhz (clk), .rst (rst), .CPU_MIO (CPU_MIO), .mem_w (mem_w),
        .addr_bus (addr_bus), .Data_out (Data_out), .Data_in (Data_in0),
        .MIO_ready (MIO_ready0), .sw (sw), .led (led0)
`ifdef MIO_ERR_EN
        , .bus_err (bus_err0)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    // Reference state: memory contents, LED register, counter as (value, edge it was valid after).
    logic [31:0] ram_m [logic [31:0]];
    logic [15:0] led_m = '0;
    logic [31:0] cnt_base = '0;
    int          cnt_edge = 0;
    logic [31:0] din_m = '0;
    logic [31:0] ram_addrs [8] = '{32'h0000_0000, 32'h0000_0010, 32'h0000_0014, 32'h0000_0100,
                                   32'h0000_0200, 32'h0000_03F8, 32'h0000_0800, 32'h0000_0FFC};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // 0 RAM, 1 LED, 2 SW, 3 counter, 4 unmapped
    function automatic int region(input logic [31:0] a);
        logic [31:0] wa;
        wa = a & 32'hFFFF_FFFC;
        if (wa < (32'd1 << (RAM_AW + 2))) return 0;
        if (wa == 32'hF000_0000) return 1;
        if (wa == 32'hF000_0004) return 2;
        if (wa == 32'hF000_0008) return 3;
        return 4;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        CPU_MIO = 1'b0;
        repeat (2) @(negedge clk);
        cnt_base = '0;
        cnt_edge = cyc;
        led_m = '0;
        din_m = '0;
        check("rst_data_in", Data_in, 32'h0);
        check("rst_ready", 32'(MIO_ready), 32'h0);
        check("rst_led", 32'(led), 32'h0);
        rst = 1'b0;
    endtask

    // One complete transaction; CPU_MIO is released at negedge drop_n after the request.
    task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] wd, input int drop_n);
        int          rg, e, last, lat, lat0, np, np0;
        logic [31:0] exp_rd, din_at;
        logic        exp_err, err_at;
        rg = region(a);
        addr_bus = a;
        mem_w = w;
        Data_out = wd;
        CPU_MIO = 1'b1;
        e = cyc + 1;
        exp_err = (rg == 4) || (rg == 2 && w);
        case (rg)
            0:       exp_rd = ram_m.exists(a & ~32'h3) ? ram_m[a & ~32'h3] : 32'hx;
            1:       exp_rd = {16'h0, led_m};
            2:       exp_rd = {16'h0, sw};
            3:       exp_rd = cnt_base + 32'(e + W - cnt_edge);
`ifdef MIO_ERR_EN
            default: exp_rd = 32'hDEAD_BEEF;
`else
            default: exp_rd = 32'h0;
`endif
        endcase
        lat = 0; lat0 = 0; np = 0; np0 = 0;
        din_at = 'x; err_at = 1'bx;
        last = ((drop_n > W + 2) ? drop_n : W + 2) + 3;
        for (int n = 1; n <= last; n++) begin
            @(negedge clk);
            if (MIO_ready) begin
                np++;
                if (lat == 0) begin
                    lat = n;
                    din_at = Data_in;
                    err_at = bus_err;
                end
            end
            if (MIO_ready0) begin
                np0++;
                if (lat0 == 0) lat0 = n;
            end
            if (n == drop_n) CPU_MIO = 1'b0;
        end
        check("latency", 32'(lat), 32'(W + 2));
        check("pulses", 32'(np), 32'd1);
        check("latency_w0", 32'(lat0), 32'd2);
        check("pulses_w0", 32'(np0), 32'd1);
        if (!w) din_m = exp_rd;
        check(w ? "data_in_hold" : "data_in", din_at, din_m);
`ifdef MIO_ERR_EN
        check("bus_err", 32'(err_at), 32'(exp_err));
`else
        if (exp_err) din_at = din_at;
`endif
        if (w) begin
            case (rg)
                0: ram_m[a & ~32'h3] = wd;
                1: led_m = wd[15:0];
                3: begin cnt_base = wd; cnt_edge = e + W + 1; end
                default: ;
            endcase
        end
        check("led", 32'(led), 32'(led_m));
    endtask

    function automatic logic [31:0] rand_addr(input int rg);
        logic [31:0] a;
        case (rg)
            0: a = ram_addrs[$urandom_range(0, 7)];
            1: a = 32'hF000_0000;
            2: a = 32'hF000_0004;
            3: a = 32'hF000_0008;
            default: begin
                case ($urandom_range(0, 3))
                    0: a = 32'h8000_0000;
                    1: a = 32'hF000_000C;
                    2: a = 32'h0000_1000 + 32'($urandom_range(0, 255) << 2);
                    default: a = {4'hE, 28'($urandom)};
                endcase
            end
        endcase
        return a | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        int          rg, pulses, pulses0;
        logic [31:0] old;
        do_reset();

        for (int i = 0; i < 8; i++) txn(ram_addrs[i], 1'b1, $urandom, W + 2);

        txn(32'h0000_0010, 1'b1, 32'h1234_5678, W + 2);
        txn(32'h0000_0010, 1'b0, 32'h0, W + 2);
        check("ram_readback", Data_in, 32'h1234_5678);

        txn(32'hF000_0000, 1'b1, 32'h0000_00A5, W + 2);
        check("led_a5", 32'(led), 32'h00A5);
        txn(32'hF000_0000, 1'b0, 32'h0, W + 2);

        sw = 16'hBEEF;
        txn(32'hF000_0004, 1'b0, 32'h0, W + 2);
        check("sw_read", Data_in, 32'h0000_BEEF);
        txn(32'hF000_0004, 1'b1, 32'h1111_2222, W + 2);
        txn(32'hF000_0004, 1'b0, 32'h0, W + 2);

        txn(32'hF000_0008, 1'b1, 32'hFFFF_FFFE, W + 2);
        txn(32'hF000_0008, 1'b0, 32'h0, W + 2);

        txn(32'h0000_0014, 1'b0, 32'h0, 10);
        txn(32'h8000_0000, 1'b0, 32'h0, W + 2);
        txn(32'hF000_0000, 1'b0, 32'h0, 1);

        // Reset while the main instance is still waiting: its write must vanish.
        old = ram_m[32'h0000_0100];
        addr_bus = 32'h0000_0100;
        mem_w = 1'b1;
        Data_out = ~old;
        CPU_MIO = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        CPU_MIO = 1'b0;
        @(negedge clk);
        cnt_base = '0;
        cnt_edge = cyc;
        led_m = '0;
        din_m = '0;
        rst = 1'b0;
        pulses = 0;
        pulses0 = 0;
        for (int n = 0; n < 6; n++) begin
            if (MIO_ready) pulses++;
            if (MIO_ready0) pulses0++;
            @(negedge clk);
        end
        check("abort_ready", 32'(pulses), 32'd0);
        check("abort_ready_w0", 32'(pulses0), 32'd0);
        check("abort_data_in", Data_in, 32'h0);
        check("abort_led", 32'(led), 32'h0);
        txn(32'h0000_0100, 1'b0, 32'h0, W + 2);
        check("abort_ram_old", Data_in, old);

        for (int i = 0; i < 60; i++) begin
            rg = $urandom_range(0, 7);
            if (rg > 4) rg = 0;
            sw = 16'($urandom);
            txn(rand_addr(rg), 1'($urandom), $urandom, (($urandom_range(0, 7) == 0) ? 1 : W + 2));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
